// File: rtl/fxp_div_arb_pkg.sv
// Shared types and helpers for the fixed-point divider arbiter.
// Optional feature macro: FXP_DIV_ARB_ZERO_CHECK_EN (carry a divide-by-zero flag with each result).
package fxp_div_arb_pkg;

    // Widest requester ID supported (NREQ up to 16)
    localparam int unsigned ID_W_MAX = 4;

    // Ceiling log2 with a floor of 1 bit so single-bit fields stay legal
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Round-robin pointer after reset: last requester, so requester 0 wins first
    function automatic int unsigned rr_rst_ptr(input int unsigned nreq);
        return nreq - 1;
    endfunction

    // Per-operation tag travelling alongside the divider pipeline
    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
`ifdef FXP_DIV_ARB_ZERO_CHECK_EN
        logic                divzero;
`endif
    } arb_tag_t;

endpackage

// File: rtl/fxp_div_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant starting the search after ptr.
module fxp_rr_arbiter
    import fxp_div_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            hold,
    output logic [NREQ-1:0] grant_c,
    output logic [IW-1:0]   grant_id_c
);

    logic          found;
    logic [IW-1:0] idx;

    // Scan ptr+1, ptr+2, ... modulo NREQ and grant the first valid requester
    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        found      = 1'b0;
        idx        = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = IW'((32'(ptr) + off) % NREQ);
            if (!hold && !found && req[idx]) begin
                grant_c[idx] = 1'b1;
                grant_id_c   = idx;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fxp_div_arbiter.sv
// Shares one pipelined fixed-point divider among NREQ requesters.
// Grants at most one divide per cycle, tracks requester IDs through a tag
// pipeline matched to DIV_LAT, and returns tagged results on a shared bus.
// Optional feature macro: FXP_DIV_ARB_ZERO_CHECK_EN (res_divzero reports a zero divisor).
module fxp_div_arbiter
    import fxp_div_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WA      = 16,
    parameter int unsigned WB      = 16,
    parameter int unsigned WO      = 16,
    parameter int unsigned DIV_LAT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hold,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*WA-1:0]             req_dividend,
    input  logic [NREQ*WB-1:0]             req_divisor,
    output logic [WA-1:0]                  div_dividend,
    output logic [WB-1:0]                  div_divisor,
    input  logic [WO-1:0]                  div_out,
    input  logic                           div_upflow,
    input  logic                           div_downflow,
    output logic                           res_valid,
    output logic [clog2(NREQ)-1:0]         res_id,
    output logic [WO-1:0]                  res_out,
    output logic                           res_upflow,
    output logic                           res_downflow,
    output logic                           res_divzero,
    output logic [clog2(DIV_LAT+2)-1:0]    inflight,
    output logic                           busy
);

    localparam int unsigned      IW      = clog2(NREQ);
    localparam int unsigned      FW      = clog2(DIV_LAT + 2);
    localparam logic [IW-1:0]    PTR_RST = IW'(rr_rst_ptr(NREQ));

    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_id;
    logic          accept;
    logic          retire;
    logic [WA-1:0] sel_dividend;
    logic [WB-1:0] sel_divisor;
    arb_tag_t      issue_tag;
    arb_tag_t      tag_q [0:DIV_LAT];

    // Reset also blocks grants so req_ready reads 0 while rst is low
    fxp_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req        (req_valid),
        .ptr        (ptr),
        .hold       (hold | ~rst),
        .grant_c    (req_ready),
        .grant_id_c (grant_id)
    );

    assign accept = |req_ready;
    // The tag in the last shift stage becomes the visible result on the next edge
    assign retire = tag_q[DIV_LAT-1].valid;

    // Select the granted requester's operand slices
    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_dividend = req_dividend[i*WA +: WA];
                sel_divisor  = req_divisor[i*WB +: WB];
            end
        end
    end

    // Build the tag that enters the pipeline on this edge
    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = accept;
        issue_tag.id    = ID_W_MAX'(grant_id);
`ifdef FXP_DIV_ARB_ZERO_CHECK_EN
        issue_tag.divzero = accept && (sel_divisor == '0);
`endif
    end

    // Operand registers, round-robin pointer, tag shift register and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            ptr          <= PTR_RST;
            inflight     <= '0;
            for (int unsigned k = 0; k <= DIV_LAT; k++) tag_q[k] <= '0;
        end else begin
            if (accept) begin
                div_dividend <= sel_dividend;
                div_divisor  <= sel_divisor;
                ptr          <= grant_id;
            end
            tag_q[0] <= issue_tag;
            for (int unsigned k = 1; k <= DIV_LAT; k++) tag_q[k] <= tag_q[k-1];
            case ({accept, retire})
                2'b10:   inflight <= inflight + FW'(1);
                2'b01:   inflight <= inflight - FW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign busy = (inflight != '0);

    // Result bus: divider outputs pass through only while a tagged result is present
    assign res_valid    = tag_q[DIV_LAT].valid;
    assign res_id       = res_valid ? IW'(tag_q[DIV_LAT].id) : '0;
    assign res_out      = res_valid ? div_out : '0;
    assign res_upflow   = res_valid & div_upflow;
    assign res_downflow = res_valid & div_downflow;
`ifdef FXP_DIV_ARB_ZERO_CHECK_EN
    assign res_divzero  = res_valid & tag_q[DIV_LAT].divzero;
`else
    assign res_divzero  = 1'b0;
`endif

endmodule
